// File: rtl/zigbee_pkg.sv
// Shared types and defaults for the ZigBee TX symbol scheduler.
//   sched_state_t     : scheduler FSM states
//   SYM_W             : default symbol width (bits)
//   CHIPS_PER_SYMBOL  : default chip slots presented per symbol
package zigbee_pkg;

  localparam int unsigned SYM_W            = 4;
  localparam int unsigned CHIPS_PER_SYMBOL = 32;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitData,
    StSpread,
    StDone
  } sched_state_t;

endpackage

// File: rtl/zigbee_symbol_scheduler.sv
// TX symbol scheduler: pops symbols from the input FIFO and presents each one
// for CHIPS_PER_SYMBOL chip slots to the spreader, prefetching the next symbol
// so a frame streams gaplessly while the FIFO keeps up.
//   inClock / inReset       : clock, asynchronous active-high reset
//   inStart / inFrameLen    : frame start pulse and length in symbols
//   inAbort                 : synchronous abort back to idle
//   inFifoEmpty/inFifoData  : input FIFO status and read data
//   outFifoReadEnable       : one-cycle pop request
//   inDownFull              : downstream cannot take a chip this cycle
//   outSymbol/outChipIndex  : symbol and chip slot being presented
//   outChipValid            : chip slot presented
//   outBusy/outDone         : frame in progress / end-of-frame pulse
//   outUnderrun             : sticky FIFO-empty-mid-frame flag
module zigbee_symbol_scheduler
  import zigbee_pkg::*;
#(
  parameter int unsigned SYM_W            = zigbee_pkg::SYM_W,
  parameter int unsigned CHIPS_PER_SYMBOL = zigbee_pkg::CHIPS_PER_SYMBOL,
  parameter int unsigned LEN_W            = 8,
  parameter int unsigned FIFO_RD_LAT      = 1,
  localparam int unsigned IdxW            = $clog2(CHIPS_PER_SYMBOL)
) (
  input  logic             inClock,
  input  logic             inReset,
  input  logic             inStart,
  input  logic [LEN_W-1:0] inFrameLen,
  input  logic             inAbort,
  input  logic             inFifoEmpty,
  input  logic [SYM_W-1:0] inFifoData,
  output logic             outFifoReadEnable,
  input  logic             inDownFull,
  output logic [SYM_W-1:0] outSymbol,
  output logic [IdxW-1:0]  outChipIndex,
  output logic             outChipValid,
  output logic             outBusy,
  output logic             outDone,
  output logic             outUnderrun
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(CHIPS_PER_SYMBOL - 1);

  sched_state_t           state_q, state_d;
  logic [LEN_W-1:0]       remaining_q, remaining_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [SYM_W-1:0]       sym_q, sym_d;
  logic [SYM_W-1:0]       next_q, next_d;
  logic                   next_valid_q, next_valid_d;
  logic                   spread_any_q, spread_any_d;
  logic                   underrun_q, underrun_d;
  // One bit per cycle of read latency; the top bit marks data landing this cycle.
  logic [FIFO_RD_LAT-1:0] rd_pipe_q, rd_pipe_d;

  logic rd_en, landing, in_flight, accept, last_acc;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    idx_d        = idx_q;
    sym_d        = sym_q;
    next_d       = next_q;
    next_valid_d = next_valid_q;
    spread_any_d = spread_any_q;
    underrun_d   = underrun_q;
    rd_en        = 1'b0;
    outChipValid = 1'b0;
    outDone      = 1'b0;
    landing      = rd_pipe_q[FIFO_RD_LAT-1];
    in_flight    = |rd_pipe_q;
    accept       = (state_q == StSpread) && !inDownFull;
    last_acc     = accept && (idx_q == LastIdx);

    unique case (state_q)
      StIdle: begin
        if (inStart && (inFrameLen != '0)) begin
          remaining_d  = inFrameLen;
          underrun_d   = 1'b0;
          spread_any_d = 1'b0;
          next_valid_d = 1'b0;
          state_d      = StFetch;
        end
      end
      StFetch: begin
        if (!inFifoEmpty) begin
          rd_en   = 1'b1;
          state_d = StWaitData;
        end else if (spread_any_q) begin
          underrun_d = 1'b1;
        end
      end
      StWaitData: begin
        if (landing) begin
          sym_d        = inFifoData;
          idx_d        = '0;
          spread_any_d = 1'b1;
          state_d      = StSpread;
        end
      end
      StSpread: begin
        outChipValid = 1'b1;
        // Prefetch only while symbols beyond the current one are still unaccounted for.
        if (!next_valid_q && (remaining_q > LEN_W'(1)) && !inFifoEmpty && !in_flight) begin
          rd_en = 1'b1;
        end
        if (landing && !last_acc) begin
          next_d       = inFifoData;
          next_valid_d = 1'b1;
        end
        if (accept) begin
          if (last_acc) begin
            remaining_d = remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              state_d = StDone;
            end else if (next_valid_q) begin
              sym_d        = next_q;
              idx_d        = '0;
              next_valid_d = 1'b0;
            end else if (landing) begin
              // Prefetch data arriving on the last chip bypasses the next register.
              sym_d = inFifoData;
              idx_d = '0;
            end else begin
              // A read already on its way is treated as the fetch for the next symbol.
              state_d = (in_flight || rd_en) ? StWaitData : StFetch;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StDone: begin
        outDone = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (inAbort) begin
      state_d      = StIdle;
      remaining_d  = '0;
      next_valid_d = 1'b0;
      underrun_d   = underrun_q;
      rd_en        = 1'b0;
      outDone      = 1'b0;
    end

    rd_pipe_d[0] = rd_en;
    for (int i = 1; i < int'(FIFO_RD_LAT); i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
    if (inAbort) begin
      rd_pipe_d = '0;
    end
  end

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      idx_q        <= '0;
      sym_q        <= '0;
      next_q       <= '0;
      next_valid_q <= 1'b0;
      spread_any_q <= 1'b0;
      underrun_q   <= 1'b0;
      rd_pipe_q    <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      idx_q        <= idx_d;
      sym_q        <= sym_d;
      next_q       <= next_d;
      next_valid_q <= next_valid_d;
      spread_any_q <= spread_any_d;
      underrun_q   <= underrun_d;
      rd_pipe_q    <= rd_pipe_d;
    end
  end

  assign outFifoReadEnable = rd_en;
  assign outSymbol         = sym_q;
  assign outChipIndex      = idx_q;
  assign outBusy           = (state_q != StIdle);
  assign outUnderrun       = underrun_q;

endmodule

// File: tb/tb_zigbee_symbol_scheduler.sv
// Directed bench for zigbee_symbol_scheduler with a one-cycle-latency FIFO model.
module tb_zigbee_symbol_scheduler;

  logic       inClock = 1'b0;
  logic       inReset, inStart, inAbort, inDownFull;
  logic [7:0] inFrameLen;
  logic       inFifoEmpty;
  logic [3:0] inFifoData = '0;
  logic       outFifoReadEnable, outChipValid, outBusy, outDone, outUnderrun;
  logic [3:0] outSymbol;
  logic [4:0] outChipIndex;

  int vec_cnt = 0;
  int err_cnt = 0;

  zigbee_symbol_scheduler dut (
    .inClock           (inClock),
    .inReset           (inReset),
    .inStart           (inStart),
    .inFrameLen        (inFrameLen),
    .inAbort           (inAbort),
    .inFifoEmpty       (inFifoEmpty),
    .inFifoData        (inFifoData),
    .outFifoReadEnable (outFifoReadEnable),
    .inDownFull        (inDownFull),
    .outSymbol         (outSymbol),
    .outChipIndex      (outChipIndex),
    .outChipValid      (outChipValid),
    .outBusy           (outBusy),
    .outDone           (outDone),
    .outUnderrun       (outUnderrun)
  );

  always #5 inClock = ~inClock;

  // FIFO model: data valid the cycle after a read enable.
  logic [3:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign inFifoEmpty = (wr_ptr == rd_ptr);

  always @(posedge inClock) begin
    if (outFifoReadEnable && !inFifoEmpty) begin
      inFifoData <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Monitor, sampling just before each rising edge.
  int cyc = 0;
  int valid_cyc, first_valid, last_valid, reads, done_cnt, done_cyc, acc_n;
  logic [3:0] acc_sym [0:511];
  logic [4:0] acc_idx [0:511];

  always @(posedge inClock) begin
    if (outChipValid) begin
      valid_cyc++;
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
    end
    if (outChipValid && !inDownFull && acc_n < 512) begin
      acc_sym[acc_n] = outSymbol;
      acc_idx[acc_n] = outChipIndex;
      acc_n++;
    end
    if (outFifoReadEnable) reads++;
    if (outDone) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    valid_cyc   = 0;
    first_valid = -1;
    last_valid  = -1;
    reads       = 0;
    done_cnt    = 0;
    done_cyc    = -1;
    acc_n       = 0;
  endtask

  task automatic push(input logic [3:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic start(input int len);
    @(negedge inClock);
    inFrameLen = 8'(len);
    inStart    = 1'b1;
    @(negedge inClock);
    inStart    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge inClock);
      n++;
    end
    check(tag, (done_cnt > 0) ? 1 : 0, 1);
  endtask

  task automatic wait_chip(input string tag, input logic [3:0] sym, input int idx,
                           input int budget);
    int found = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge inClock);
      if (outChipValid && outSymbol == sym && outChipIndex == 5'(idx)) begin
        found = 1;
        break;
      end
    end
    check(tag, found, 1);
  endtask

  task automatic wait_underrun(input string tag, input int budget);
    int n = 0;
    while (!outUnderrun && n < budget) begin
      @(negedge inClock);
      n++;
    end
    check(tag, outUnderrun, 1);
  endtask

  task automatic check_seq(input string tag, input logic [3:0] s0, input logic [3:0] s1,
                           input logic [3:0] s2, input int nsym);
    int bad = 0;
    logic [3:0] e;
    check({tag, "_count"}, acc_n, nsym * 32);
    for (int k = 0; k < nsym * 32 && k < acc_n; k++) begin
      e = (k / 32 == 0) ? s0 : (k / 32 == 1) ? s1 : s2;
      if (acc_sym[k] !== e || acc_idx[k] !== 5'(k % 32)) bad++;
    end
    check({tag, "_bad"}, bad, 0);
  endtask

  int r0;

  initial begin
    inReset    = 1'b1;
    inStart    = 1'b0;
    inAbort    = 1'b0;
    inDownFull = 1'b0;
    inFrameLen = '0;
    clear_mon();
    repeat (2) @(negedge inClock);
    check("rst_busy",  outBusy, 0);
    check("rst_valid", outChipValid, 0);
    check("rst_read",  outFifoReadEnable, 0);
    check("rst_done",  outDone, 0);
    check("rst_under", outUnderrun, 0);
    check("rst_sym",   outSymbol, 0);
    check("rst_idx",   outChipIndex, 0);
    inReset = 1'b0;

    // Reset in the middle of spreading.
    clear_mon();
    push(4'h2);
    push(4'h3);
    start(2);
    wait_chip("r_reach", 4'h2, 5, 100);
    r0 = reads;
    inReset = 1'b1;
    @(posedge inClock);
    #1;
    check("r_busy",  outBusy, 0);
    check("r_valid", outChipValid, 0);
    check("r_sym",   outSymbol, 0);
    check("r_idx",   outChipIndex, 0);
    check("r_read",  outFifoReadEnable, 0);
    repeat (3) @(negedge inClock);
    check("r_reads", reads, r0);
    inReset = 1'b0;
    wr_ptr  = rd_ptr;
    repeat (3) @(negedge inClock);
    check("r_idle", outBusy, 0);

    // Nominal three-symbol frame, no backpressure.
    clear_mon();
    push(4'h1);
    push(4'h4);
    push(4'h9);
    start(3);
    wait_done("a_done", 300);
    check("a_valid",  valid_cyc, 96);
    check("a_contig", last_valid - first_valid + 1, 96);
    check("a_reads",  reads, 3);
    check("a_dlat",   done_cyc - last_valid, 1);
    check("a_dcnt",   done_cnt, 1);
    check("a_busy",   outBusy, 0);
    check_seq("a_seq", 4'h1, 4'h4, 4'h9, 3);

    // Backpressure for five cycles at index 10.
    clear_mon();
    push(4'h1);
    push(4'h4);
    push(4'h9);
    start(3);
    wait_chip("b_reach", 4'h1, 10, 100);
    inDownFull = 1'b1;
    repeat (5) @(negedge inClock);
    check("b_hold_idx", outChipIndex, 10);
    check("b_hold_sym", outSymbol, 4'h1);
    inDownFull = 1'b0;
    wait_done("b_done", 300);
    check("b_valid", valid_cyc, 101);
    check("b_reads", reads, 3);
    check_seq("b_seq", 4'h1, 4'h4, 4'h9, 3);

    // Underrun: second symbol arrives late.
    clear_mon();
    push(4'hD);
    start(2);
    wait_underrun("c_under", 100);
    check("c_gap_valid", outChipValid, 0);
    check("c_gap_busy",  outBusy, 1);
    check("c_gap_acc",   acc_n, 32);
    repeat (4) @(negedge inClock);
    push(4'h6);
    wait_done("c_done", 200);
    check("c_sticky", outUnderrun, 1);
    check("c_reads",  reads, 2);
    check_seq("c_seq", 4'hD, 4'h6, 4'h0, 2);

    // Abort at index 20 of the second symbol.
    clear_mon();
    push(4'hA);
    push(4'hB);
    push(4'hC);
    start(3);
    check("d_under_clr", outUnderrun, 0);
    wait_chip("d_reach", 4'hB, 20, 200);
    inAbort = 1'b1;
    @(negedge inClock);
    inAbort = 1'b0;
    check("d_busy",  outBusy, 0);
    check("d_valid", outChipValid, 0);
    repeat (5) @(negedge inClock);
    check("d_nodone", done_cnt, 0);
    check("d_reads",  reads, 3);
    check("d_idle",   outBusy, 0);
    wr_ptr = rd_ptr;

    // Zero-length start and start while busy are ignored.
    clear_mon();
    push(4'h5);
    start(0);
    repeat (3) @(negedge inClock);
    check("e_len0_busy",  outBusy, 0);
    check("e_len0_reads", reads, 0);
    start(1);
    wait_chip("e_reach", 4'h5, 3, 50);
    inFrameLen = 8'd4;
    inStart    = 1'b1;
    @(negedge inClock);
    inStart    = 1'b0;
    wait_done("e_done", 100);
    repeat (3) @(negedge inClock);
    check("e_dcnt",  done_cnt, 1);
    check("e_reads", reads, 1);
    check("e_busy",  outBusy, 0);
    check_seq("e_seq", 4'h5, 4'h0, 4'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
